// File: rtl/bcd_pkg.sv
// Shared types and helpers for the multi-cycle double-dabble converter.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    // Decimal digits needed to hold the largest WIDTH-bit unsigned value.
    function automatic int digits_for(input int width);
        longint unsigned maxv;
        int              d;
        maxv = (64'd1 << width) - 64'd1;
        d    = 1;
        while (maxv > 64'd9) begin
            maxv = maxv / 64'd10;
            d    = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_conv_if.sv
// Two-requester conversion bus: requests/operands in, grants and packed BCD result out.
interface bcd_conv_if
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                        req0;
    logic [WIDTH-1:0]            bin0;
    logic                        req1;
    logic [WIDTH-1:0]            bin1;
    logic                        gnt0;
    logic                        gnt1;
    logic                        busy;
    logic [DIGIT_W*DIGITS-1:0]   bcd;
    logic                        bcd_valid;
    logic                        bcd_id;

    modport master (
        output req0, bin0, req1, bin1,
        input  gnt0, gnt1, busy, bcd, bcd_valid, bcd_id
    );

    modport slave (
        input  req0, bin0, req1, bin1,
        output gnt0, gnt1, busy, bcd, bcd_valid, bcd_id
    );
endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit above 4, then shift {acc, bin} left by one.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic [DIGIT_W*DIGITS+WIDTH-1:0] din,
    output logic [DIGIT_W*DIGITS+WIDTH-1:0] dout
);
    localparam int ACC_W = DIGIT_W * DIGITS;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] corr;

    assign acc = din[ACC_W+WIDTH-1:WIDTH];

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        // Corrected digit stays <= 12, so the 4-bit add never carries out.
        assign corr[d*DIGIT_W +: DIGIT_W] = (acc[d*DIGIT_W +: DIGIT_W] > 4'd4)
            ? acc[d*DIGIT_W +: DIGIT_W] + 4'd3
            : acc[d*DIGIT_W +: DIGIT_W];
    end

    assign dout = {corr[ACC_W-2:0], din[WIDTH-1:0], 1'b0};

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin shared binary-to-BCD converter: one grant, WIDTH shift cycles, one result pulse.
module bcd_conv_arbiter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    bcd_conv_if.slave  bus
);
    localparam int ACC_W = DIGIT_W * DIGITS;
    localparam int TOT_W = ACC_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    if (DIGITS < digits_for(WIDTH)) begin : g_digits_check
        $error("bcd_conv_arbiter: DIGITS too small for WIDTH");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   bin_sr_q, bin_sr_d;
    logic               cur_id_q, cur_id_d;
    logic               last_id_q, last_id_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               bcd_valid_q, bcd_valid_d;
    logic               bcd_id_q, bcd_id_d;
    logic               busy_q, busy_d;
    logic               gnt0, gnt1;
    logic [TOT_W-1:0]   step_out;

    bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_step (
        .din  ({acc_q, bin_sr_q}),
        .dout (step_out)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        bin_sr_d    = bin_sr_q;
        cur_id_d    = cur_id_q;
        last_id_d   = last_id_q;
        bcd_d       = bcd_q;
        bcd_id_d    = bcd_id_q;
        bcd_valid_d = 1'b0;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the requester not served last wins.
                if (bus.req0 && (!bus.req1 || last_id_q)) gnt0 = 1'b1;
                else if (bus.req1)                        gnt1 = 1'b1;
                if (gnt0 || gnt1) begin
                    bin_sr_d = gnt1 ? bus.bin1 : bus.bin0;
                    acc_d    = '0;
                    cnt_d    = '0;
                    cur_id_d = gnt1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                {acc_d, bin_sr_d} = step_out;
                cnt_d = cnt_q + CNT_W'(1);
                // Result registers load on the edge into DONE so they are visible during DONE.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = DONE;
                    bcd_d       = step_out[TOT_W-1:WIDTH];
                    bcd_id_d    = cur_id_q;
                    last_id_d   = cur_id_q;
                    bcd_valid_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            bin_sr_q    <= '0;
            cur_id_q    <= 1'b0;
            last_id_q   <= 1'b1;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            bcd_id_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            bin_sr_q    <= bin_sr_d;
            cur_id_q    <= cur_id_d;
            last_id_q   <= last_id_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            bcd_id_q    <= bcd_id_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.busy      = busy_q;
    assign bus.bcd       = bcd_q;
    assign bus.bcd_valid = bcd_valid_q;
    assign bus.bcd_id    = bcd_id_q;

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Sequential double-dabble binary-to-BCD converter shared between two requesters in the calculator datapath, typically the operand-entry display path and the result display path. It arbitrates round-robin, captures one binary operand per conversion, performs one shift-and-correct iteration per clock, and presents a registered packed-BCD result with a one-cycle valid pulse and the ID of the requester served. Its result matches the combinational converter bit-for-bit for all inputs, and it replaces per-requester combinational converters with one shared multi-cycle unit.

## Interface
- WIDTH, 8, binary operand width.
- DIGITS, 3, BCD digit count. Must satisfy 10^DIGITS > 2^WIDTH − 1.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0  in  1  requester 0 wants a conversion. Held with bin0 stable until gnt0.
- bin0  in  WIDTH  requester 0 operand
- req1  in  1  requester 1 wants a conversion. Held with bin1 stable until gnt1.
- bin1  in  WIDTH  requester 1 operand
- gnt0  out  1  combinational. bin0 is captured on the rising edge that ends this cycle.
- gnt1  out  1  combinational. Same as gnt0, for requester 1.
- busy  out  1  registered. High in SHIFT and DONE.
- bcd  out  4*DIGITS  registered packed BCD. Digit 0 is in bits [3:0].
- bcd_valid  out  1  registered one-cycle pulse marking a new bcd
- bcd_id  out  1  registered. Requester owning the current bcd.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - With no request: gnt0 = gnt1 = 0.
  - With exactly one request: grant that requester.
  - With both requesting: grant the requester that is not last_id.
  - On the grant edge: load the selected bin into the binary shift register, clear the BCD accumulator, set cnt = 0, record cur_id, go to SHIFT.
- SHIFT, once per cycle:
  - Add 3 to every accumulator digit > 4.
  - Then shift {acc, bin_sr} left one bit.
  - Increment cnt.
  - When cnt reaches WIDTH−1 on this edge (WIDTH shifts done), go to DONE.
  - The correction step runs before every shift, including the first. It is a no-op on the first iteration. No correction runs after the last shift.
- DONE
  - bcd ← acc, bcd_id ← cur_id, last_id ← cur_id, bcd_valid pulses.
  - Go to IDLE.
- No grant is issued in SHIFT or DONE, even if requests are pending.
- bcd and bcd_id hold their value until the next DONE.
- A requester dropping req before its grant simply withdraws. There is no penalty and no state change.
- Digit arithmetic is 4-bit modulo. A corrected digit never exceeds 12 before the shift, so no digit carries into the next.

## Timing
- Cycle 0 is the gnt cycle. SHIFT occupies cycles 1..WIDTH. DONE is cycle WIDTH+1 (cycle 9 at default): bcd_valid = 1 and the new bcd is visible.
- The next grant is possible at cycle WIDTH+2.
- Sustained throughput is one conversion per WIDTH+2 cycles.
- Reset values: state IDLE, busy 0, bcd 0, bcd_valid 0, bcd_id 0, last_id 1 (requester 0 wins the first tie), cnt 0.
- Reset asserted mid-conversion aborts immediately. No bcd_valid is produced, and the interrupted requester must re-request.
- A request that arrives during busy is serviced in the first IDLE cycle after DONE, subject to round-robin.
- gnt0 and gnt1 are mutually exclusive and are never asserted while busy = 1.

## Structure
- Shared package bcd_pkg holds:
  - the state enum (IDLE, SHIFT, DONE)
  - a constant function digits_for(width) used to check DIGITS at elaboration
  - the digit width localparam (4)
- One sub-module, bcd_dabble_step: combinational, parameterized by WIDTH and DIGITS. It takes {acc, bin_sr} and returns the corrected-then-shifted pair. The top level contains only the FSM, arbiter, counter and registers.

## Test plan
- Single conversion: req0 with bin0 = 8'd255 → gnt0 in cycle 0, bcd = 12'h255, bcd_valid pulse in cycle 9, bcd_id = 0, busy high in cycles 1..9.
- Exhaustive: req1 with bin1 = 0..255 in sequence → every result equals the decimal encoding (0 → 12'h000, 99 → 12'h099, 100 → 12'h100, 128 → 12'h128) and bcd_id = 1.
- Tie and fairness: req0 and req1 held continuously with bin0 = 12, bin1 = 34 → grants alternate 0,1,0,1 starting with 0, results alternate 12'h012 / 12'h034, grants spaced 10 cycles apart.
- Request during busy: req1 raised in cycle 3 of a requester-0 conversion → gnt1 in cycle 10, no grant earlier.
- Reset mid-operation: rst_n low in cycle 5 → all outputs at reset values asynchronously, no bcd_valid. After release, a fresh req0 with 8'd7 → 12'h007.
- Withdrawn request: req0 pulsed for one cycle while busy, then dropped → no grant to 0, and no bcd_valid beyond the in-flight conversion.
